imem_port_arbiter: RTL and testbench

- Shares the single instruction-side MMU/icache port between two fetch requesters.
  - Requester 0: the prefetch FIFO.
  - Requester 1: a secondary fetch source, e.g. debug program-buffer or trace reader.
- Sequences each access as translate (MMU), then fetch (icache), then respond.
- Round-robin arbitration between the two requesters.
- Flush-safe: an in-flight icache response after a flush is drained and discarded, never delivered.
- Sits between the prefetch stage and the MMU/icache top.

---
 rtl/imem_port_arbiter_if.sv | 28 ++
 rtl/imem_port_arbiter.sv | 88 ++++++++
 tb/tb_imem_port_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if: requester, MMU and icache signals of the instruction-port arbiter
interface imem_port_arbiter_if #(parameter int XLEN = 32);
  logic [1:0]      req_i;
  logic [XLEN-1:0] vaddr0_i;
  logic [XLEN-1:0] vaddr1_i;
  logic            flush_i;
  logic [1:0]      ack_o;
  logic [1:0]      err_o;
  logic [XLEN-1:0] rdata_o;
  logic [1:0]      grant_o;
  logic            busy_o;
  logic            mmu_req_o;
  logic [XLEN-1:0] mmu_vaddr_o;
  logic            mmu_hit_i;
  logic [XLEN-1:0] mmu_paddr_i;
  logic            icache_req_o;
  logic [XLEN-1:0] icache_addr_o;
  logic            icache_ack_i;
  logic [XLEN-1:0] icache_rdata_i;
  modport slave (
    input  req_i, vaddr0_i, vaddr1_i, flush_i, mmu_hit_i, mmu_paddr_i, icache_ack_i, icache_rdata_i,
    output ack_o, err_o, rdata_o, grant_o, busy_o, mmu_req_o, mmu_vaddr_o, icache_req_o, icache_addr_o
  );
  modport master (
    output req_i, vaddr0_i, vaddr1_i, flush_i, mmu_hit_i, mmu_paddr_i, icache_ack_i, icache_rdata_i,
    input  ack_o, err_o, rdata_o, grant_o, busy_o, mmu_req_o, mmu_vaddr_o, icache_req_o, icache_addr_o
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: round-robin sharing of the MMU/icache port between two fetchers, flush-safe; IMEM_ARB_TIMEOUT_EN adds a watchdog
module imem_port_arbiter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imem_port_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, XLATE, FETCH, DRAIN} state_t;
  state_t          r_state, w_next;
  logic [1:0]      r_grant;
  logic            r_last;
  logic [XLEN-1:0] r_vaddr, r_paddr;
  logic            w_take, w_ack, w_err, w_tout, w_win;
  // On contention the requester that did not win last time takes the port
  assign w_win = &bus.req_i ? ~r_last : bus.req_i[1];
`ifdef IMEM_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] r_cnt;
  assign w_tout = (r_cnt == LIMIT);
  // Watchdog restarts on every state change and counts while a transaction is open
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= (w_next != r_state) ? '0 : ((r_state != IDLE) ? r_cnt + 1'b1 : r_cnt);
`else
  logic w_unused_cfg;
  assign w_tout       = 1'b0;
  assign w_unused_cfg = |TIMEOUT_CYCLES;
`endif
  // Next state plus ack/err pulses; flush outranks completion, completion outranks timeout
  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    w_ack  = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      IDLE:  if (!bus.flush_i && |bus.req_i) begin
               w_next = XLATE;
               w_take = 1'b1;
             end
      XLATE: if (bus.flush_i) w_next = IDLE;
             else if (bus.mmu_hit_i) w_next = FETCH;
             else if (w_tout) begin
               w_next = IDLE;
               w_err  = 1'b1;
             end
      FETCH: if (bus.flush_i) w_next = bus.icache_ack_i ? IDLE : DRAIN;
             else if (bus.icache_ack_i) begin
               w_next = IDLE;
               w_ack  = 1'b1;
             end
             else if (w_tout) begin
               w_next = IDLE;
               w_err  = 1'b1;
             end
      DRAIN: if (bus.icache_ack_i || w_tout) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // State, owner and address registers; addresses are captured once and then ignored upstream
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= 2'b00;
      r_last  <= 1'b1;
      r_vaddr <= '0;
      r_paddr <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_grant <= w_win ? 2'b10 : 2'b01;
        r_last  <= w_win;
        r_vaddr <= w_win ? bus.vaddr1_i : bus.vaddr0_i;
      end
      if (r_state == XLATE && bus.mmu_hit_i && !bus.flush_i) r_paddr <= bus.mmu_paddr_i;
    end
  assign bus.grant_o       = (r_state == XLATE || r_state == FETCH) ? r_grant : 2'b00;
  assign bus.busy_o        = (r_state != IDLE);
  assign bus.mmu_req_o     = (r_state == XLATE);
  assign bus.mmu_vaddr_o   = r_vaddr;
  assign bus.icache_req_o  = (r_state == FETCH || r_state == DRAIN);
  assign bus.icache_addr_o = r_paddr;
  assign bus.ack_o         = w_ack ? r_grant : 2'b00;
  assign bus.err_o         = w_err ? r_grant : 2'b00;
  assign bus.rdata_o       = w_ack ? bus.icache_rdata_i : '0;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed and randomized transactions against a transaction-level round-robin model
module tb_imem_port_arbiter;
  localparam int XLEN = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int last_owner = 1;
  always #5 clk = ~clk;
  imem_port_arbiter_if #(.XLEN(XLEN)) bus ();
  imem_port_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic quiet;
    bus.req_i = 2'b00; bus.vaddr0_i = '0; bus.vaddr1_i = '0; bus.flush_i = 1'b0;
    bus.mmu_hit_i = 1'b0; bus.mmu_paddr_i = '0; bus.icache_ack_i = 1'b0; bus.icache_rdata_i = '0;
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, 32'(bus.ack_o), 0);
    check({tag, "_err"}, 32'(bus.err_o), 0);
    check({tag, "_grant"}, 32'(bus.grant_o), 0);
    check({tag, "_busy"}, 32'(bus.busy_o), 0);
    check({tag, "_mmu_req"}, 32'(bus.mmu_req_o), 0);
    check({tag, "_ic_req"}, 32'(bus.icache_req_o), 0);
    check({tag, "_mmu_vaddr"}, bus.mmu_vaddr_o, 0);
    check({tag, "_ic_addr"}, bus.icache_addr_o, 0);
  endtask
  // Round-robin rule: a lone requester wins; on contention the one that did not win last
  function automatic int pick(input logic [1:0] req);
    return (req == 2'b11) ? 1 - last_owner : ((req == 2'b01) ? 0 : 1);
  endfunction
  // mode: 0 normal, 1 flush with hit in XLATE, 2 flush early in FETCH (drain), 3 flush with ack in FETCH
  task automatic txn(input logic [1:0] req, input logic [31:0] va, input logic [31:0] pa,
                     input logic [31:0] data, input int hl, input int al, input int mode);
    int w;
    logic [1:0] oh;
    logic [1:0] exp_ack;
    logic drain;
    w = pick(req);
    oh = (w == 1) ? 2'b10 : 2'b01;
    bus.req_i = req;
    bus.vaddr0_i = (w == 0) ? va : $urandom;
    bus.vaddr1_i = (w == 1) ? va : $urandom;
    bus.flush_i = 1'b0; bus.mmu_hit_i = 1'b0; bus.icache_ack_i = 1'b0;
    #1;
    check("idle_busy", 32'(bus.busy_o), 0);
    check("idle_grant", 32'(bus.grant_o), 0);
    last_owner = w;
    tick;
    bus.vaddr0_i = $urandom; bus.vaddr1_i = $urandom; bus.req_i = 2'($urandom);
    for (int i = 0; i <= hl; i++) begin
      bus.mmu_hit_i = (i == hl);
      bus.mmu_paddr_i = (i == hl) ? pa : $urandom;
      bus.flush_i = (mode == 1 && i == hl);
      #1;
      check("xl_mmu_req", 32'(bus.mmu_req_o), 1);
      check("xl_ic_req", 32'(bus.icache_req_o), 0);
      check("xl_grant", 32'(bus.grant_o), 32'(oh));
      check("xl_vaddr", bus.mmu_vaddr_o, va);
      check("xl_ack", 32'(bus.ack_o), 0);
      tick;
    end
    bus.mmu_hit_i = 1'b0;
    bus.flush_i = 1'b0;
    if (mode == 1) begin
      bus.req_i = 2'b00;
      #1;
      check("fx_busy", 32'(bus.busy_o), 0);
      check("fx_ic_req", 32'(bus.icache_req_o), 0);
      check("fx_ack", 32'(bus.ack_o), 0);
      return;
    end
    drain = 1'b0;
    for (int i = 0; i < al; i++) begin
      bus.icache_ack_i = 1'b0;
      bus.icache_rdata_i = $urandom;
      bus.flush_i = (mode == 2 && i == 0) || (drain && $urandom_range(0, 1) == 1);
      #1;
      check("fe_ic_req", 32'(bus.icache_req_o), 1);
      check("fe_mmu_req", 32'(bus.mmu_req_o), 0);
      check("fe_ack", 32'(bus.ack_o), 0);
      check("fe_grant", 32'(bus.grant_o), drain ? 0 : 32'(oh));
      check("fe_addr", bus.icache_addr_o, pa);
      if (mode == 2 && i == 0) drain = 1'b1;
      tick;
    end
    bus.icache_ack_i = 1'b1;
    bus.icache_rdata_i = data;
    bus.flush_i = (mode == 3) || (drain && $urandom_range(0, 1) == 1);
    #1;
    exp_ack = (drain || mode == 3) ? 2'b00 : oh;
    check("rsp_ack", 32'(bus.ack_o), 32'(exp_ack));
    check("rsp_rdata", bus.rdata_o, (exp_ack != 2'b00) ? data : 0);
    check("rsp_err", 32'(bus.err_o), 0);
    check("rsp_ic_req", 32'(bus.icache_req_o), 1);
    check("rsp_grant", 32'(bus.grant_o), drain ? 0 : 32'(oh));
    tick;
    bus.icache_ack_i = 1'b0; bus.flush_i = 1'b0; bus.req_i = 2'b00;
    #1;
    check("post_busy", 32'(bus.busy_o), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int mode, al;
    quiet;
    #1;
    check_all_zero("reset");
    #10;
    rst_n = 1'b1;
    tick;
    last_owner = 1;
    for (int k = 0; k < 3; k++) txn(2'b11, $urandom, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 0);
    txn(2'b01, 32'h8000_0004, 32'h0000_1004, 32'h0041_0113, 0, 0, 0);
    bus.req_i = 2'b11; bus.flush_i = 1'b1;
    #1;
    tick;
    bus.flush_i = 1'b0; bus.req_i = 2'b00;
    #1;
    check("idle_flush_busy", 32'(bus.busy_o), 0);
    check("idle_flush_grant", 32'(bus.grant_o), 0);
    txn(2'b10, $urandom, $urandom, $urandom, 0, 0, 1);
    txn(2'b11, $urandom, $urandom, $urandom, 1, 3, 2);
    txn(2'b01, 32'h0000_2000, 32'h0000_3000, 32'hcafe_f00d, 0, 0, 0);
    txn(2'b11, $urandom, $urandom, $urandom, 0, 1, 3);
    for (int k = 0; k < 40; k++) begin
      mode = $urandom_range(0, 3);
      al = (mode == 2) ? $urandom_range(1, 3) : $urandom_range(0, 3);
      txn(2'($urandom_range(1, 3)), $urandom, $urandom, $urandom, $urandom_range(0, 3), al, mode);
    end
`ifdef IMEM_ARB_TIMEOUT_EN
    quiet;
    bus.req_i = 2'b10;
    bus.vaddr1_i = 32'h1234_5678;
    last_owner = pick(2'b10);
    tick;
    bus.req_i = 2'b00;
    for (int k = 0; k < 8; k++) begin
      check("to_wait_err", 32'(bus.err_o), 0);
      check("to_wait_mmu", 32'(bus.mmu_req_o), 1);
      tick;
    end
    check("to_err", 32'(bus.err_o), 32'(2'b10));
    check("to_ack", 32'(bus.ack_o), 0);
    tick;
    check("to_busy", 32'(bus.busy_o), 0);
`endif
    quiet;
    bus.req_i = 2'b01;
    bus.vaddr0_i = 32'h0000_0abc;
    tick;
    bus.req_i = 2'b00;
    bus.mmu_hit_i = 1'b1;
    bus.mmu_paddr_i = 32'h0000_0def;
    tick;
    bus.mmu_hit_i = 1'b0;
    #1;
    check("arst_pre_ic_req", 32'(bus.icache_req_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("arst");
    #1;
    rst_n = 1'b1;
    tick;
    last_owner = 1;
    txn(2'b11, $urandom, $urandom, $urandom, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
